kvs_rx_parser: RTL and testbench
================================

# kvs_rx_parser

Single-clock receive-side parser for memcached binary requests carried over UDP/IPv4/Ethernet. Sits directly on the GMII receive interface and strips the preamble and SFD. Filters on destination UDP port and extracts opcode, key, opaque, source IP/port and UDP request ID into a descriptor. The descriptor is handed to the key-value engine over a valid/ready handshake. It replaces fixed-offset header latching with a parametrised key buffer, request validation, back-pressure and statistics.

## Interface
- PORT, 16'd11211, UDP destination port accepted
- KEY_MAX, 32, key buffer depth in bytes (1..250)
- rx_clk  in  1  receive clock; all logic on its rising edge
- sys_rst  in  1  asynchronous, active-high reset
- rx_dv  in  1  GMII receive data valid
- rxd  in  8  GMII receive data
- req_valid  out  1  descriptor valid
- req_ready  in  1  consumer accepts descriptor
- req_opcode  out  8  memcached opcode (0x00 GET, 0x01 SET)
- req_keylen  out  8  key length in bytes, 1..KEY_MAX
- req_key  out  8*KEY_MAX  key; first key byte in bits [8*KEY_MAX-1 -: 8], unused bytes zero
- req_opaque  out  32  opaque field
- req_src_ip  out  32  IPv4 source address
- req_src_port  out  16  UDP source port
- req_udp_id  out  16  memcached UDP frame request ID
- stat_req  out  16  count of published descriptors, wraps
- stat_overrun  out  16  count of good requests dropped because req_valid was still high, wraps

## Operation
- Byte index b counts from 0 at the first byte after the 0xD5 SFD; b saturates at 2047.
- States and transitions:
  - IDLE → PRE when rx_dv rises.
  - PRE → HDR when rxd==0xD5.
  - PRE → IDLE when rx_dv falls.
  - HDR → KEY when b==73 and no check has failed. With extlen==0, KEY starts at b=74.
  - KEY → TAIL after keylen bytes.
  - Any state → DROP on a check failure.
  - TAIL/DROP → END when rx_dv falls.
  - END → IDLE after one cycle.
- Checks, each evaluated at its byte:
  - ethertype (b12–13)==0x0800
  - b14==0x45
  - proto (b23)==0x11
  - dst port (b36–37)==PORT
  - magic (b50)==0x80
  - opcode (b51) ∈ {0x00,0x01}
  - keylen high byte (b52)==0
  - 1 ≤ keylen (b53) ≤ KEY_MAX
- Field offsets:
  - src IP b26–29
  - src port b34–35
  - UDP request ID b42–43
  - extlen b54
  - opaque b62–65
  - key starts at b 74+extlen
- rx_dv falling before the last key byte is a truncation and the frame is dropped.
- On END with no failure:
  - If req_valid is low: load the descriptor, assert req_valid, increment stat_req.
  - Otherwise: discard the descriptor and increment stat_overrun.
- Descriptor outputs are stable while req_valid is high. req_valid clears on the edge where req_valid&&req_ready.
- Acceptance and a new publication in the same cycle: the new descriptor loads and req_valid stays high.
- Reset mid-frame: parser returns to IDLE. The rest of the frame is ignored until rx_dv falls and rises again.

## Timing
- Reset values:
  - req_valid=0
  - all req_* fields=0
  - stat_req=0
  - stat_overrun=0
  - state=IDLE
- Latency: req_valid rises at the 2nd rising edge after the last edge sampling rx_dv=1.
- req_ready is combinationally unused. There is no path from req_ready to any output within a cycle.
- Back-to-back frames with a minimum 12-cycle IFG must all be parsed.

## Configuration
- KVS_RX_FCS_CHECK_EN defined:
  - CRC-32 runs over bytes b≥0 through the final byte.
  - At END the residue must equal 0xC704DD7B, otherwise the frame is dropped silently, with no stat increment.
  - Latency is unchanged.
- KVS_RX_FCS_CHECK_EN undefined: FCS is ignored and no CRC logic is instantiated.

## Structure
- Shared package kvs_pkg holds:
  - MAGIC_REQ=8'h80, MAGIC_RESP=8'h81
  - CMD_GET, CMD_SET
  - ETH_TYPE_IPV4, IP_PROTO_UDP
  - the byte-offset constants above
  - the parser state enum
- One sub-module, kvs_rx_fcs: byte-wide CRC-32 with init/enable/residue output, compiled only under KVS_RX_FCS_CHECK_EN.

## Test plan
- GET, key "foo", keylen 3, extlen 0, opaque 0xDEADBEEF, from 10.0.21.99:40000, req_ready=1 → one req_valid pulse with:
  - req_key top bytes 0x666F6F, rest zero
  - stat_req=1
- Same frame with dst port 11212, and again with magic 0x81 → no req_valid; stat counters unchanged.
- SET, extlen 8, keylen=KEY_MAX (32) → full key captured. Repeat with keylen 33 → dropped.
- Two good frames back-to-back with req_ready=0 → first descriptor held unchanged; stat_overrun=1.
- Frame truncated at b=60 → no req_valid. Next good frame parsed correctly.
- sys_rst pulsed at b=55 → outputs are at reset values at once. Parser resynchronises on the next frame.
- With KVS_RX_FCS_CHECK_EN: a correct FCS publishes; flipping one FCS bit → no req_valid.

Source files
------------

// File: rtl/kvs_pkg.sv
// Shared constants, frame byte offsets and parser state encoding for the KVS receive path.
package kvs_pkg;

   localparam logic [7:0]  MAGIC_REQ     = 8'h80;
   localparam logic [7:0]  MAGIC_RESP    = 8'h81;
   localparam logic [7:0]  CMD_GET       = 8'h00;
   localparam logic [7:0]  CMD_SET       = 8'h01;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
   localparam logic [7:0]  GMII_SFD      = 8'hD5;
   localparam logic [31:0] FCS_RESIDUE   = 32'hC704DD7B;

   // Offsets count from the first byte after the SFD.
   localparam logic [10:0] OFF_ETYPE    = 11'd12;
   localparam logic [10:0] OFF_VER_IHL  = 11'd14;
   localparam logic [10:0] OFF_PROTO    = 11'd23;
   localparam logic [10:0] OFF_SRC_IP   = 11'd26;
   localparam logic [10:0] OFF_SRC_PORT = 11'd34;
   localparam logic [10:0] OFF_DST_PORT = 11'd36;
   localparam logic [10:0] OFF_UDP_ID   = 11'd42;
   localparam logic [10:0] OFF_MAGIC    = 11'd50;
   localparam logic [10:0] OFF_OPCODE   = 11'd51;
   localparam logic [10:0] OFF_KEYLEN   = 11'd52;
   localparam logic [10:0] OFF_EXTLEN   = 11'd54;
   localparam logic [10:0] OFF_OPAQUE   = 11'd62;
   localparam logic [10:0] OFF_KEY      = 11'd74;

   typedef enum logic [2:0] {
      ST_IDLE, ST_PRE, ST_HDR, ST_KEY, ST_TAIL, ST_DROP, ST_END
   } kvs_rx_state_t;

endpackage

// File: rtl/kvs_rx_fcs.sv
// Byte-wide reflected CRC-32 over the frame; o_residue is the bit-reversed register, one byte per cycle.
// Present only when KVS_RX_FCS_CHECK_EN is defined.
`ifdef KVS_RX_FCS_CHECK_EN
module kvs_rx_fcs (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [7:0]  i_dat,
   output logic [31:0] o_residue
);
   logic [31:0] r_crc;
   logic [31:0] w_crc;

   always_comb begin
      w_crc = r_crc;
      for (int i = 0; i < 8; i++)
         w_crc = (w_crc[0] ^ i_dat[i]) ? ((w_crc >> 1) ^ 32'hEDB88320) : (w_crc >> 1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_crc <= '1;
      else if (i_init) r_crc <= '1;
      else if (i_en)   r_crc <= w_crc;
   end

   always_comb begin
      o_residue = '0;
      for (int i = 0; i < 32; i++) o_residue[i] = r_crc[31-i];
   end
endmodule
`endif

// File: rtl/kvs_rx_parser.sv
// GMII memcached-over-UDP request parser: descriptor valid 2 edges after last rx_dv; one-deep, overruns counted.
// KVS_RX_FCS_CHECK_EN adds an Ethernet FCS residue check at end of frame.
module kvs_rx_parser
   import kvs_pkg::*;
#(
   parameter logic [15:0] PORT    = 16'd11211,
   parameter int          KEY_MAX = 32
) (
   input  logic                  rx_clk,
   input  logic                  sys_rst,
   input  logic                  rx_dv,
   input  logic [7:0]            rxd,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [7:0]            req_opcode,
   output logic [7:0]            req_keylen,
   output logic [8*KEY_MAX-1:0]  req_key,
   output logic [31:0]           req_opaque,
   output logic [31:0]           req_src_ip,
   output logic [15:0]           req_src_port,
   output logic [15:0]           req_udp_id,
   output logic [15:0]           stat_req,
   output logic [15:0]           stat_overrun
);
   localparam logic [7:0] KMAX8 = 8'(KEY_MAX);

   kvs_rx_state_t r_state, w_next;
   logic                 r_dv_q, r_good;
   logic [10:0]          r_b;
   logic [7:0]           r_kidx, r_keylen, r_ext, r_opc;
   logic [31:0]          r_opaque, r_sip;
   logic [15:0]          r_sport, r_uid;
   logic [8*KEY_MAX-1:0] r_kbuf;
   logic                 w_fail, w_sfd, w_publish, w_load, w_fcs_ok;
   logic [10:0]          w_key_m1;

   assign w_sfd    = (r_state == ST_PRE) && rx_dv && (rxd == GMII_SFD);
   assign w_key_m1 = OFF_KEY - 11'd1 + {3'b000, r_ext};

   always_comb begin
      w_fail = 1'b0;
      case (r_b)
         OFF_ETYPE:             w_fail = (rxd != ETH_TYPE_IPV4[15:8]);
         OFF_ETYPE + 11'd1:     w_fail = (rxd != ETH_TYPE_IPV4[7:0]);
         OFF_VER_IHL:           w_fail = (rxd != IPV4_VER_IHL);
         OFF_PROTO:             w_fail = (rxd != IP_PROTO_UDP);
         OFF_DST_PORT:          w_fail = (rxd != PORT[15:8]);
         OFF_DST_PORT + 11'd1:  w_fail = (rxd != PORT[7:0]);
         OFF_MAGIC:             w_fail = (rxd != MAGIC_REQ);
         OFF_OPCODE:            w_fail = (rxd != CMD_GET) && (rxd != CMD_SET);
         OFF_KEYLEN:            w_fail = (rxd != 8'h00);
         OFF_KEYLEN + 11'd1:    w_fail = (rxd == 8'h00) || (rxd > KMAX8);
         default:               w_fail = 1'b0;
      endcase
   end

   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Losing rx_dv before the last key byte lands in DROP, i.e. truncation.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (rx_dv && !r_dv_q) w_next = ST_PRE;
         ST_PRE:  if (!rx_dv) w_next = ST_IDLE;
                  else if (rxd == GMII_SFD) w_next = ST_HDR;
         ST_HDR:  if (!rx_dv || w_fail) w_next = ST_DROP;
                  else if (r_b == w_key_m1) w_next = ST_KEY;
         ST_KEY:  if (!rx_dv) w_next = ST_DROP;
                  else if (r_kidx == r_keylen - 8'd1) w_next = ST_TAIL;
         ST_TAIL, ST_DROP: if (!rx_dv) w_next = ST_END;
         ST_END:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef KVS_RX_FCS_CHECK_EN
   logic [31:0] w_residue;
   kvs_rx_fcs u_fcs (
      .i_clk     (rx_clk),
      .i_rst     (sys_rst),
      .i_init    (w_sfd),
      .i_en      (rx_dv && (r_state inside {ST_HDR, ST_KEY, ST_TAIL, ST_DROP})),
      .i_dat     (rxd),
      .o_residue (w_residue)
   );
   assign w_fcs_ok = (w_residue == FCS_RESIDUE);
`else
   assign w_fcs_ok = 1'b1;
`endif

   assign w_publish = (r_state == ST_END) && r_good && w_fcs_ok;
   assign w_load    = w_publish && (!req_valid || req_ready);

   // r_dv_q resets high so a frame already in flight at reset is not mistaken for a new rx_dv rise.
   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_dv_q <= 1'b1;   r_good   <= 1'b0;   r_b     <= '0;   r_kidx <= '0;
         r_keylen <= '0;   r_ext    <= '0;     r_opc   <= '0;   r_opaque <= '0;
         r_sip    <= '0;   r_sport  <= '0;     r_uid   <= '0;   r_kbuf <= '0;
      end else begin
         r_dv_q <= rx_dv;
         r_good <= (r_state == ST_TAIL);
         if (w_sfd) begin
            r_b    <= '0;
            r_kidx <= '0;
            r_kbuf <= '0;
         end else if (rx_dv && (r_b != 11'h7FF)) begin
            r_b <= r_b + 11'd1;
         end
         if ((r_state == ST_HDR) && rx_dv) begin
            case (r_b)
               OFF_SRC_IP, OFF_SRC_IP + 11'd1, OFF_SRC_IP + 11'd2, OFF_SRC_IP + 11'd3:
                  r_sip <= {r_sip[23:0], rxd};
               OFF_SRC_PORT, OFF_SRC_PORT + 11'd1: r_sport <= {r_sport[7:0], rxd};
               OFF_UDP_ID, OFF_UDP_ID + 11'd1:     r_uid   <= {r_uid[7:0], rxd};
               OFF_OPCODE:          r_opc    <= rxd;
               OFF_KEYLEN + 11'd1:  r_keylen <= rxd;
               OFF_EXTLEN:          r_ext    <= rxd;
               OFF_OPAQUE, OFF_OPAQUE + 11'd1, OFF_OPAQUE + 11'd2, OFF_OPAQUE + 11'd3:
                  r_opaque <= {r_opaque[23:0], rxd};
               default: ;
            endcase
         end
         if ((r_state == ST_KEY) && rx_dv) begin
            for (int i = 0; i < KEY_MAX; i++)
               if (r_kidx == 8'(i)) r_kbuf[8*(KEY_MAX-1-i) +: 8] <= rxd;
            r_kidx <= r_kidx + 8'd1;
         end
      end
   end

   always_ff @(posedge rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         req_valid  <= 1'b0;  req_opcode <= '0;  req_keylen   <= '0;  req_key    <= '0;
         req_opaque <= '0;    req_src_ip <= '0;  req_src_port <= '0;  req_udp_id <= '0;
         stat_req   <= '0;    stat_overrun <= '0;
      end else if (w_load) begin
         req_valid    <= 1'b1;
         req_opcode   <= r_opc;
         req_keylen   <= r_keylen;
         req_key      <= r_kbuf;
         req_opaque   <= r_opaque;
         req_src_ip   <= r_sip;
         req_src_port <= r_sport;
         req_udp_id   <= r_uid;
         stat_req     <= stat_req + 16'd1;
      end else begin
         if (req_valid && req_ready) req_valid <= 1'b0;
         if (w_publish) stat_overrun <= stat_overrun + 16'd1;
      end
   end

endmodule

// File: tb/tb_kvs_rx_parser.sv
// Randomised and directed frames against a byte-array reference model of the memcached request parser.
module tb_kvs_rx_parser;
   localparam int KEY_MAX = 32;

   logic         rx_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         rx_dv = 1'b0;
   logic [7:0]   rxd = 8'h00;
   logic         req_ready = 1'b1;
   logic         req_valid;
   logic [7:0]   req_opcode, req_keylen;
   logic [255:0] req_key;
   logic [31:0]  req_opaque, req_src_ip;
   logic [15:0]  req_src_port, req_udp_id, stat_req, stat_overrun;

   kvs_rx_parser #(.PORT(16'd11211), .KEY_MAX(KEY_MAX)) dut (
      .rx_clk(rx_clk), .sys_rst(sys_rst), .rx_dv(rx_dv), .rxd(rxd),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_keylen(req_keylen), .req_key(req_key), .req_opaque(req_opaque),
      .req_src_ip(req_src_ip), .req_src_port(req_src_port), .req_udp_id(req_udp_id),
      .stat_req(stat_req), .stat_overrun(stat_overrun)
   );

   always #5 rx_clk = ~rx_clk;

   typedef struct packed {
      logic [7:0]   opc;
      logic [7:0]   kl;
      logic [255:0] key;
      logic [31:0]  opaque;
      logic [31:0]  sip;
      logic [15:0]  sport;
      logic [15:0]  uid;
   } desc_t;

   int    n_chk = 0, n_err = 0;
   int    cyc = 0, rise_cyc = -1, last_dv_cyc = 0;
   int    e_req = 0, e_ovr = 0;
   bit    pend = 0, fcs_bad = 0, prev_v = 0;
   desc_t held, last_acc;
   desc_t got_q[$], exp_q[$];
   logic [7:0] fr[$];
   logic [7:0] kbytes[64];
   logic [7:0]  f_magic;
   logic [15:0] f_dport, f_sport, f_uid;
   logic [31:0] f_opaque, f_sip;

   function automatic desc_t cur_desc();
      return {req_opcode, req_keylen, req_key, req_opaque, req_src_ip, req_src_port, req_udp_id};
   endfunction

   task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge rx_clk) cyc++;

   always @(negedge rx_clk) begin
      if (req_valid && req_ready) begin
         got_q.push_back(cur_desc());
         last_acc = cur_desc();
      end
      if (req_valid && !prev_v) rise_cyc = cyc;
      prev_v = req_valid;
   end

   task automatic set_defaults();
      f_magic = 8'h80; f_dport = 16'd11211; f_opaque = $urandom; f_sip = $urandom;
      f_sport = 16'($urandom); f_uid = 16'($urandom); fcs_bad = 0;
      for (int i = 0; i < 64; i++) kbytes[i] = 8'($urandom);
   endtask

   task automatic mk_frame(input int opc, input int kl, input int ext, input int nkey, input int nval);
      fr.delete();
      for (int i = 0; i < 74 + ext + nkey + nval; i++) fr.push_back(8'($urandom));
      fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'h11;
      for (int i = 0; i < 4; i++) fr[26+i] = f_sip[31-8*i -: 8];
      for (int i = 0; i < 4; i++) fr[62+i] = f_opaque[31-8*i -: 8];
      fr[34] = f_sport[15:8]; fr[35] = f_sport[7:0];
      fr[36] = f_dport[15:8]; fr[37] = f_dport[7:0];
      fr[42] = f_uid[15:8];   fr[43] = f_uid[7:0];
      fr[50] = f_magic; fr[51] = 8'(opc); fr[52] = 8'h00; fr[53] = 8'(kl); fr[54] = 8'(ext);
      for (int i = 0; i < nkey; i++) fr[74+ext+i] = kbytes[i];
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fr[i]) begin
         c = c ^ {24'h0, fr[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
   endtask

   // Expected descriptor of a frame of which the first len bytes are delivered.
   function automatic bit model(input int len, output desc_t d);
      int ext, kl;
      bit ok;
      d = '0;
      if (len < 55) return 1'b0;
      ext = int'(fr[54]);
      kl  = int'(fr[53]);
      ok = ({fr[12], fr[13]} == 16'h0800) && (fr[14] == 8'h45) && (fr[23] == 8'h11) &&
           ({fr[36], fr[37]} == 16'd11211) && (fr[50] == 8'h80) && (fr[51] <= 8'h01) &&
           (fr[52] == 8'h00) && (kl >= 1) && (kl <= KEY_MAX) && (len >= 74 + ext + kl);
`ifdef KVS_RX_FCS_CHECK_EN
      ok = ok && (len == fr.size()) && !fcs_bad;
`endif
      if (!ok) return 1'b0;
      d.opc = fr[51]; d.kl = fr[53];
      d.sip = {fr[26], fr[27], fr[28], fr[29]};
      d.opaque = {fr[62], fr[63], fr[64], fr[65]};
      d.sport = {fr[34], fr[35]};
      d.uid = {fr[42], fr[43]};
      for (int i = 0; i < kl; i++) d.key[255-8*i -: 8] = fr[74+ext+i];
      return 1'b1;
   endfunction

   task automatic send(input int len, input int rst_at);
      for (int i = 0; i < 8; i++) begin
         @(posedge rx_clk); #1;
         rx_dv = 1'b1; rxd = (i == 7) ? 8'hD5 : 8'h55;
      end
      for (int i = 0; i < len; i++) begin
         @(posedge rx_clk); #1;
         rx_dv = 1'b1; rxd = fr[i]; last_dv_cyc = cyc + 1;
         if (i == rst_at) begin
            #2 sys_rst = 1'b1;
            #1;
            chk("rst_mid/valid", req_valid, 0);
            chk("rst_mid/stat_req", stat_req, 0);
            chk("rst_mid/stat_ovr", stat_overrun, 0);
            chk("rst_mid/desc", cur_desc(), '0);
            #1 sys_rst = 1'b0;
         end
      end
      @(posedge rx_clk); #1;
      rx_dv = 1'b0; rxd = 8'h00;
      repeat (14) @(posedge rx_clk);
      #1;
   endtask

   task automatic run(input int len, input int rst_at, input string tag);
      desc_t d;
      bit g;
      g = model(len, d);
      got_q.delete();
      send(len, rst_at);
      if (rst_at >= 0) begin
         e_req = 0; e_ovr = 0; pend = 0;
      end else if (g) begin
         if (pend) e_ovr++;
         else begin
            e_req++;
            if (req_ready) exp_q.push_back(d);
            else begin pend = 1; held = d; end
         end
      end
      chk({tag, "/accepts"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "/desc"}, got_q[i], exp_q[i]);
      chk({tag, "/stat_req"}, stat_req, e_req);
      chk({tag, "/stat_ovr"}, stat_overrun, e_ovr);
      chk({tag, "/valid"}, req_valid, pend);
      if (pend) chk({tag, "/held"}, cur_desc(), held);
      exp_q.delete();
   endtask

   initial begin
      int mode, kl, ext, len;
      logic [255:0] kfoo;

      repeat (3) @(posedge rx_clk);
      #1 sys_rst = 1'b0;
      chk("reset/valid", req_valid, 0);
      chk("reset/stat_req", stat_req, 0);
      chk("reset/stat_ovr", stat_overrun, 0);
      chk("reset/desc", cur_desc(), '0);
      repeat (3) @(posedge rx_clk);
      #1;

      set_defaults();
      f_opaque = 32'hDEADBEEF; f_sip = 32'h0A001563; f_sport = 16'd40000;
      kbytes[0] = 8'h66; kbytes[1] = 8'h6F; kbytes[2] = 8'h6F;
      mk_frame(0, 3, 0, 3, 0); add_fcs();
      run(fr.size(), -1, "get_foo");
      kfoo = '0; kfoo[255:232] = 24'h666F6F;
      chk("get_foo/key", last_acc.key, kfoo);
      chk("get_foo/latency", rise_cyc - last_dv_cyc, 2);

      f_dport = 16'd11212;
      mk_frame(0, 3, 0, 3, 0); add_fcs();
      run(fr.size(), -1, "dport_11212");
      f_dport = 16'd11211; f_magic = 8'h81;
      mk_frame(0, 3, 0, 3, 0); add_fcs();
      run(fr.size(), -1, "magic_81");

      set_defaults();
      mk_frame(1, KEY_MAX, 8, KEY_MAX, 6); add_fcs();
      run(fr.size(), -1, "set_kmax");
      chk("set_kmax/keylen", last_acc.kl, KEY_MAX);
      mk_frame(1, KEY_MAX + 1, 8, KEY_MAX + 1, 6); add_fcs();
      run(fr.size(), -1, "set_k33");

      set_defaults();
      mk_frame(0, 5, 0, 5, 0); add_fcs();
      run(60, -1, "trunc60");
      set_defaults();
      mk_frame(1, 7, 2, 7, 3); add_fcs();
      run(fr.size(), -1, "after_trunc");

      for (int n = 0; n < 40; n++) begin
         set_defaults();
         mode = $urandom_range(0, 12);
         kl   = $urandom_range(1, KEY_MAX);
         ext  = $urandom_range(0, 8);
         mk_frame($urandom_range(0, 1), kl, ext, kl, $urandom_range(0, 6));
         case (mode)
            1: fr[12] = fr[12] ^ 8'h01;
            2: fr[14] = 8'h46;
            3: fr[23] = 8'h06;
            4: fr[37] = fr[37] ^ 8'h01;
            5: fr[50] = 8'h81;
            6: fr[51] = 8'($urandom_range(2, 255));
            7: fr[52] = 8'($urandom_range(1, 255));
            8: fr[53] = 8'h00;
            9: fr[53] = 8'($urandom_range(KEY_MAX + 1, 255));
            default: ;
         endcase
         add_fcs();
         len = fr.size();
         if (mode == 10) len = $urandom_range(20, fr.size() - 1);
         run(len, -1, "rnd");
      end

      req_ready = 1'b0;
      set_defaults();
      mk_frame(0, 4, 0, 4, 0); add_fcs();
      run(fr.size(), -1, "hold_a");
      set_defaults();
      mk_frame(1, 9, 3, 9, 2); add_fcs();
      run(fr.size(), -1, "overrun_b");
      set_defaults();
      mk_frame(0, 6, 0, 6, 0); add_fcs();
      run(fr.size(), 55, "rst_b55");
      req_ready = 1'b1;
      set_defaults();
      mk_frame(0, 11, 1, 11, 0); add_fcs();
      run(fr.size(), -1, "resync");

`ifdef KVS_RX_FCS_CHECK_EN
      set_defaults();
      mk_frame(1, 8, 0, 8, 4); add_fcs();
      run(fr.size(), -1, "fcs_good");
      set_defaults();
      mk_frame(1, 8, 0, 8, 4); add_fcs();
      fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h10;
      fcs_bad = 1;
      run(fr.size(), -1, "fcs_flip");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
